// File: rtl/fetch_ctrl.sv
// Fetch-side control: registers the ROM instruction into IR and resolves JMP/BZ/HALT,
// feeding Branch/Target/Halt back to the fetch stage.
module fetch_ctrl #(
    parameter int unsigned IW      = 9,
    parameter int unsigned AW      = 8,
    parameter logic [3:0]  OP_JMP  = 4'hE,
    parameter logic [3:0]  OP_BZ   = 4'hD,
    parameter logic [3:0]  OP_HALT = 4'hF
) (
    input  logic          CLK,
    input  logic          Init,
    input  logic [AW-1:0] PC,
    input  logic [IW-1:0] Instr,
    input  logic          Zero,
    output logic          Branch,
    output logic [AW-1:0] Target,
    output logic          Halt,
    output logic [IW-1:0] IR,
    output logic [AW-1:0] IRPC,
    output logic          IRValid,
    output logic [7:0]    BrCount
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]    state;
    logic [3:0]    opcode;
    logic [AW-1:0] offset_sext;
    logic [AW-1:0] branch_target;
    logic          taken;
    logic          is_halt;
    logic [7:0]    br_count_inc;

    assign opcode        = Instr[IW-1 -: 4];
    assign offset_sext   = {{(AW-5){Instr[4]}}, Instr[4:0]};
    // Natural AW-bit wrap gives the mod 2^AW target.
    assign branch_target = PC + offset_sext;
    assign taken         = (opcode == OP_JMP) || ((opcode == OP_BZ) && Zero);
    assign is_halt       = (opcode == OP_HALT);
    assign br_count_inc  = (BrCount == 8'hFF) ? BrCount : BrCount + 8'd1;

    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            state   <= ST_RUN;
            Branch  <= 1'b0;
            Target  <= '0;
            Halt    <= 1'b0;
            IR      <= '0;
            IRPC    <= '0;
            IRValid <= 1'b0;
            BrCount <= 8'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    IR      <= Instr;
                    IRPC    <= PC;
                    IRValid <= 1'b1;
                    Branch  <= 1'b0;
                    if (taken) begin
                        Branch  <= 1'b1;
                        Target  <= branch_target;
                        BrCount <= br_count_inc;
                        state   <= ST_FLUSH;
                    end else if (is_halt) begin
                        Halt  <= 1'b1;
                        state <= ST_HALTED;
                    end
                end
                // Wrong-path slot: squash whatever was fetched at PC+1.
                ST_FLUSH: begin
                    IRValid <= 1'b0;
                    Branch  <= 1'b0;
                    state   <= ST_RUN;
                end
                ST_HALTED: begin
                    IRValid <= 1'b0;
                    Branch  <= 1'b0;
                end
                default: begin
                    Branch  <= 1'b0;
                    IRValid <= 1'b0;
                    state   <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a small IF model and ROM close the fetch loop around the DUT.
module tb_fetch_ctrl;

    logic       CLK = 1'b0;
    logic       Init;
    logic [7:0] PC;
    logic [8:0] Instr;
    logic       Zero;
    logic       Branch;
    logic [7:0] Target;
    logic       Halt;
    logic [8:0] IR;
    logic [7:0] IRPC;
    logic       IRValid;
    logic [7:0] BrCount;

    logic [8:0] rom [256];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .CLK(CLK), .Init(Init), .PC(PC), .Instr(Instr), .Zero(Zero),
        .Branch(Branch), .Target(Target), .Halt(Halt), .IR(IR), .IRPC(IRPC),
        .IRValid(IRValid), .BrCount(BrCount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] mk(input logic [3:0] op, input int off);
        logic [4:0] o;
        o = off[4:0];
        return {op, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 9'd0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Init  = 1'b1;
        PC    = 8'd0;
        Instr = rom[0];
        @(negedge CLK);
        Init = 1'b0;
    endtask

    // One clock edge; IF follows its contract using the pre-edge Branch/Halt.
    task automatic step();
        logic [7:0] pc_next;
        pc_next = Halt ? PC : (Branch ? Target : PC + 8'd1);
        @(posedge CLK);
        #1;
        PC    = pc_next;
        Instr = rom[PC];
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        Init = 1'b1; PC = 8'd0; Zero = 1'b0;
        clear_rom();
        Instr = rom[0];

        // T2 straight line, then T3 JMP at PC=4 off=+12
        rom[4] = mk(4'hE, 12);
        do_reset();
        check("rst_irvalid", IRValid, 0);
        check("rst_brcount", BrCount, 0);
        step();
        check("t2_irpc0", IRPC, 0);
        check("t2_valid0", IRValid, 1);
        steps(3);
        check("t2_irpc3", IRPC, 3);
        check("t2_branch3", Branch, 0);
        step();
        check("t3_irpc", IRPC, 4);
        check("t3_branch", Branch, 1);
        check("t3_target", Target, 16);
        check("t3_brcount", BrCount, 1);
        step();
        check("t3_bubble", IRValid, 0);
        check("t3_branch_drop", Branch, 0);
        step();
        check("t3_irpc16", IRPC, 16);
        check("t3_valid16", IRValid, 1);

        // T1 async reset mid-cycle while Branch=1
        clear_rom();
        rom[4] = mk(4'hE, 12);
        do_reset();
        steps(5);
        check("t1_pre_branch", Branch, 1);
        #2;
        Init = 1'b1;
        #1;
        check("t1_branch", Branch, 0);
        check("t1_target", Target, 0);
        check("t1_brcount", BrCount, 0);
        check("t1_ir", IR, 0);
        check("t1_irpc", IRPC, 0);
        check("t1_irvalid", IRValid, 0);
        PC = 8'd0;
        Instr = rom[0];
        @(negedge CLK);
        Init = 1'b0;
        step();
        check("t1_run_after", IRValid, 1);

        // T4 BZ at PC=8 off=-3
        clear_rom();
        rom[8] = mk(4'hD, -3);
        Zero = 1'b0;
        do_reset();
        steps(9);
        check("t4_nt_irpc", IRPC, 8);
        check("t4_nt_branch", Branch, 0);
        step();
        check("t4_nt_irpc9", IRPC, 9);
        check("t4_nt_valid", IRValid, 1);
        Zero = 1'b1;
        do_reset();
        steps(9);
        check("t4_tk_branch", Branch, 1);
        check("t4_tk_target", Target, 5);
        step();
        check("t4_tk_bubble", IRValid, 0);
        step();
        check("t4_tk_irpc5", IRPC, 5);
        Zero = 1'b0;

        // T5 wrap both directions
        clear_rom();
        rom[3] = mk(4'hE, -5);
        do_reset();
        steps(4);
        check("t5_neg_target", Target, 254);
        steps(2);
        check("t5_irpc254", IRPC, 254);
        steps(2);
        check("t5_irpc0_wrap", IRPC, 0);
        clear_rom();
        rom[250] = mk(4'hE, 10);
        do_reset();
        steps(251);
        check("t5_pos_branch", Branch, 1);
        check("t5_pos_target", Target, 4);
        steps(2);
        check("t5_irpc4", IRPC, 4);

        // T6 flush slot ignores HALT/JMP; branch-to-self; then HALT
        clear_rom();
        rom[4] = mk(4'hE, 2);
        rom[5] = mk(4'hF, 0);
        rom[6] = mk(4'hE, 0);
        rom[7] = mk(4'hE, 1);
        do_reset();
        steps(5);
        check("t6_tgt6", Target, 6);
        step();
        check("t6_flush_halt", Halt, 0);
        check("t6_flush_valid", IRValid, 0);
        step();
        check("t6_self_irpc", IRPC, 6);
        check("t6_self_target", Target, 6);
        check("t6_self_brcount", BrCount, 2);
        step();
        check("t6_flush_jmp", Branch, 0);
        check("t6_flush_cnt", BrCount, 2);
        step();
        check("t6_self_again", Branch, 1);
        check("t6_cnt3", BrCount, 3);

        clear_rom();
        rom[7] = mk(4'hF, 0);
        rom[8] = mk(4'hE, 3);
        do_reset();
        steps(8);
        check("t6_halt", Halt, 1);
        check("t6_halt_irpc", IRPC, 7);
        check("t6_halt_valid", IRValid, 1);
        steps(4);
        check("t6_halt_sticky", Halt, 1);
        check("t6_halt_novalid", IRValid, 0);
        check("t6_halt_pc", PC, 8);
        check("t6_halt_irpc_hold", IRPC, 7);
        check("t6_halt_nobranch", Branch, 0);
        check("t6_halt_cnt", BrCount, 0);
        #2;
        Init = 1'b1;
        #1;
        check("t6_init_clear", Halt, 0);
        PC = 8'd0;
        Instr = rom[0];
        @(negedge CLK);
        Init = 1'b0;

        // BrCount saturation with a branch-to-self at 0
        clear_rom();
        rom[0] = mk(4'hE, 0);
        do_reset();
        steps(599);
        check("sat_branch", Branch, 1);
        check("sat_brcount", BrCount, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
